uart_echo_buffer: RTL and testbench
===================================

# uart_echo_buffer

Byte buffer between the UART receiver and UART transmitter of the echo design. It drains received bytes from the receiver's RXNE/RD handshake into a power-of-two FIFO. It replays them to the transmitter through the TXE/WR handshake whenever the transmitter is free. This replaces the single-register loopback, so bursts arriving at line rate are echoed without loss while the FIFO has room. Overflow is flagged and counted, not silently corrupted.

## Interface
- DEPTH, 16: FIFO entries; power of two, 2..256.
- TXE_TIMEOUT, 8: cycles to wait for TXE to fall after a WR pulse before treating the byte as accepted.
- CLK  in  1  system clock (100 MHz in the echo top).
- RST_N  in  1  reset, synchronous and active-low.
- RX_D  in  8  received byte from the receiver; valid while RXNE=1.
- RXNE  in  1  receiver holds a byte.
- RX_RD  out  1  one-cycle pulse: byte consumed, receiver clears RXNE.
- TX_D  out  8  byte to the transmitter; registered.
- TX_WR  out  1  one-cycle pulse: load TX_D into the transmitter.
- TXE  in  1  transmitter idle and able to accept a byte.
- OVR_CLR  in  1  clears OVERRUN and DROP_CNT.
- COUNT  out  $clog2(DEPTH)+1  current occupancy.
- EMPTY, FULL  out  1  occupancy flags (COUNT==0, COUNT==DEPTH).
- OVERRUN  out  1  sticky: at least one byte dropped.
- DROP_CNT  out  8  dropped-byte count; saturates at 255.
- LAST_RX  out  8  most recent byte taken from the receiver (LED display).

## Operation
- Ingest FSM, states R_IDLE and R_WAIT:
  - R_IDLE with RXNE=1: capture RX_D into the FIFO (or drop it), pulse RX_RD, set LAST_RX=RX_D, go to R_WAIT.
  - R_WAIT: stay until RXNE=0, then go to R_IDLE. This prevents double reads while the receiver's flag clears.
- Push is accepted if FULL=0, or if a pop occurs in the same cycle.
- Push rejected (full with no pop):
  - RX_RD is still pulsed, so the receiver is never stalled.
  - OVERRUN<=1; DROP_CNT increments, saturating.
- Output FSM, states T_IDLE and T_WAIT:
  - T_IDLE with TXE=1 and EMPTY=0: TX_D<=head, pulse TX_WR, pop, load the timeout counter, go to T_WAIT.
  - T_WAIT: go to T_IDLE when TXE=0 is seen, or when TXE_TIMEOUT cycles expire.
  - After TXE has gone low, the next issue additionally requires TXE=1 again, which T_IDLE already checks.
- TX_D holds its value from the WR pulse until the next WR pulse.
- FIFO: read and write pointers of $clog2(DEPTH) bits wrap modulo DEPTH. COUNT tracks occupancy.
  - Simultaneous push and pop leaves COUNT unchanged.
  - Pop is never issued when EMPTY=1.
- OVR_CLR takes effect at the next edge. If a drop occurs in the same cycle, the drop wins: OVERRUN=1 and DROP_CNT=1.
- Reset (RST_N=0 at an edge):
  - Both FSMs go to idle; pointers and COUNT go to 0.
  - RX_RD=0, TX_WR=0, TX_D=0x00, LAST_RX=0x00, OVERRUN=0, DROP_CNT=0, EMPTY=1, FULL=0.
  - FIFO contents are discarded.
  - Reset mid-transfer aborts without emitting a further pulse. An RXNE still high after reset is ingested normally.

## Timing
- Edge k samples RXNE=1 in R_IDLE: RX_RD=1, COUNT+1 and LAST_RX are visible during cycle k+1. RX_RD=0 in cycle k+2.
- If TXE=1 and the buffer was empty, edge k+1 issues: TX_WR=1 and TX_D valid in cycle k+2. Minimum through-latency is 2 cycles.
- Maximum issue rate is one byte per TXE low→high cycle of the transmitter. With a non-responding TXE, it is one byte per TXE_TIMEOUT+1 cycles.
- All outputs are registered; there are no combinational paths from input to output.

## Structure
- Shared package uart_pkg: DATA_W=8, the ingest and output state encodings, and the DROP_CNT width.
- One sub-module, uart_sync_fifo (DEPTH, DATA_W; push, pop, wdata, rdata, count, full, empty). The two FSMs and the status logic stay in uart_echo_buffer.

## Test plan
- Single byte: RXNE rises with RX_D=0x41 and TXE=1. Required: RX_RD pulses once; 2 cycles later TX_WR pulses once with TX_D=0x41; LAST_RX=0x41; COUNT returns to 0.
- Burst with TXE held 0: 16 bytes 0x00..0x0F fill the FIFO with FULL=1, and a 17th byte 0xAA is dropped. Required: OVERRUN=1, DROP_CNT=1. Releasing TXE emits 0x00..0x0F in order.
- Simultaneous push and pop at FULL: a byte arrives in the same cycle as an issue. Required: accepted, COUNT stays 16, no drop.
- RXNE held high for 5 cycles. Required: exactly one RX_RD pulse and one FIFO entry.
- TXE stuck at 1 (never falls). Required: consecutive TX_WR pulses spaced exactly TXE_TIMEOUT+1 cycles apart; bytes in order.
- Reset asserted with 3 bytes queued and T_WAIT active. Required: the next cycle shows all reset values, and no TX_WR follows. OVR_CLR after an overrun returns OVERRUN=0 and DROP_CNT=0.

Source files
------------

// File: rtl/uart_pkg.sv
// uart_pkg: shared widths, FSM encodings and a saturating-increment helper for the UART echo buffer
package uart_pkg;
  localparam int DATA_W = 8;
  localparam int DROP_W = 8;
  typedef enum logic {R_IDLE, R_WAIT} r_state_t;
  typedef enum logic {T_IDLE, T_WAIT} t_state_t;
  function automatic logic [DROP_W-1:0] sat_inc(input logic [DROP_W-1:0] v);
    return &v ? v : v + 1'b1;
  endfunction
endpackage

// File: rtl/uart_echo_buffer_if.sv
// uart_echo_buffer_if: receiver (rx_d/rxne/rx_rd) and transmitter (tx_d/tx_wr/txe) handshakes
// master: the echo buffer (drives rx_rd, tx_d, tx_wr); slave: the UART receiver/transmitter side
interface uart_echo_buffer_if;
  import uart_pkg::*;
  logic [DATA_W-1:0] rx_d;
  logic rxne;
  logic rx_rd;
  logic [DATA_W-1:0] tx_d;
  logic tx_wr;
  logic txe;
  modport master (input rx_d, rxne, txe, output rx_rd, tx_d, tx_wr);
  modport slave (output rx_d, rxne, txe, input rx_rd, tx_d, tx_wr);
endinterface

// File: rtl/uart_sync_fifo.sv
// uart_sync_fifo: power-of-two synchronous FIFO with occupancy count
// ports: clk, rst_n (sync, active-low), push/wdata, pop/rdata (head, combinational), count, full, empty
module uart_sync_fifo #(
  parameter int DEPTH = 16,
  parameter int DATA_W = 8,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic push,
  input  logic pop,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic [AW:0] count,
  output logic full,
  output logic empty
);
  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  always_comb begin
    rdata = mem[rptr];
    full = count == (AW+1)'(DEPTH);
    empty = count == '0;
  end
  always_ff @(posedge clk)
    if (push) mem[wptr] <= wdata;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wptr <= '0;
      rptr <= '0;
      count <= '0;
    end else begin
      wptr <= wptr + AW'(push);
      rptr <= rptr + AW'(pop);
      count <= count + (AW+1)'(push) - (AW+1)'(pop);
    end
  end
endmodule

// File: rtl/uart_echo_buffer.sv
// uart_echo_buffer: FIFO between UART receiver and transmitter with overrun accounting
// ports: clk, rst_n (sync, active-low), bus (rx/tx handshakes), ovr_clr, count, empty, full,
// overrun (sticky), drop_cnt (saturating), last_rx
module uart_echo_buffer import uart_pkg::*; #(
  parameter int DEPTH = 16,
  parameter int TXE_TIMEOUT = 8,
  localparam int AW = $clog2(DEPTH),
  localparam int TW = $clog2(TXE_TIMEOUT + 1)
) (
  input  logic clk,
  input  logic rst_n,
  uart_echo_buffer_if.master bus,
  input  logic ovr_clr,
  output logic [AW:0] count,
  output logic empty,
  output logic full,
  output logic overrun,
  output logic [DROP_W-1:0] drop_cnt,
  output logic [DATA_W-1:0] last_rx
);
  r_state_t r_state;
  r_state_t r_next;
  t_state_t t_state;
  t_state_t t_next;
  logic [TW-1:0] tmr;
  logic [DATA_W-1:0] head;
  logic take;
  logic pop;
  logic push;
  logic drop;
  uart_sync_fifo #(.DEPTH(DEPTH), .DATA_W(DATA_W)) fifo (
    .clk,
    .rst_n,
    .push,
    .pop,
    .wdata(bus.rx_d),
    .rdata(head),
    .count,
    .full,
    .empty
  );
  // a full FIFO still accepts a byte when the head leaves in the same cycle
  // R_WAIT is held for as long as rxne stays high, so both states share one next-state rule
  always_comb begin
    take = r_state == R_IDLE && bus.rxne;
    pop = t_state == T_IDLE && bus.txe && !empty;
    push = take && (!full || pop);
    drop = take && !push;
    r_next = bus.rxne ? R_WAIT : R_IDLE;
    t_next = t_state == T_IDLE ? (pop ? T_WAIT : T_IDLE) : (!bus.txe || tmr == TW'(1) ? T_IDLE : T_WAIT);
  end
  // a drop in the same cycle as ovr_clr restarts the count at one
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= R_IDLE;
      t_state <= T_IDLE;
      tmr <= '0;
      bus.rx_rd <= 1'b0;
      bus.tx_wr <= 1'b0;
      bus.tx_d <= '0;
      last_rx <= '0;
      overrun <= 1'b0;
      drop_cnt <= '0;
    end else begin
      r_state <= r_next;
      t_state <= t_next;
      bus.rx_rd <= take;
      bus.tx_wr <= pop;
      if (take) last_rx <= bus.rx_d;
      if (pop) bus.tx_d <= head;
      tmr <= pop ? TW'(TXE_TIMEOUT) : t_state == T_WAIT ? tmr - 1'b1 : tmr;
      overrun <= drop || (overrun && !ovr_clr);
      drop_cnt <= drop ? sat_inc(ovr_clr ? '0 : drop_cnt) : ovr_clr ? '0 : drop_cnt;
    end
  end
endmodule

// File: tb/tb_uart_echo_buffer.sv
// tb_uart_echo_buffer: directed self-checking bench for uart_echo_buffer
module tb_uart_echo_buffer;
  logic clk;
  logic rst_n;
  logic ovr_clr;
  logic [4:0] count;
  logic empty;
  logic full;
  logic overrun;
  logic [7:0] drop_cnt;
  logic [7:0] last_rx;
  int checks;
  int errors;
  int cyc;
  int rd_n;
  int n0;
  logic [7:0] tx_q[$];
  int tx_t[$];
  uart_echo_buffer_if bus();
  uart_echo_buffer #(.DEPTH(16), .TXE_TIMEOUT(8)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus),
    .ovr_clr(ovr_clr),
    .count(count),
    .empty(empty),
    .full(full),
    .overrun(overrun),
    .drop_cnt(drop_cnt),
    .last_rx(last_rx)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (bus.rx_rd) rd_n <= rd_n + 1;
    if (bus.tx_wr) begin
      tx_q.push_back(bus.tx_d);
      tx_t.push_back(cyc);
    end
  end
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic send(input logic [7:0] b);
    bus.rx_d = b;
    bus.rxne = 1'b1;
    tick();
    bus.rxne = 1'b0;
    tick();
  endtask
  task automatic chk_reset(input string tag);
    chk({tag, " rx_rd"}, 32'(bus.rx_rd), 0);
    chk({tag, " tx_wr"}, 32'(bus.tx_wr), 0);
    chk({tag, " tx_d"}, 32'(bus.tx_d), 0);
    chk({tag, " last_rx"}, 32'(last_rx), 0);
    chk({tag, " overrun"}, 32'(overrun), 0);
    chk({tag, " drop_cnt"}, 32'(drop_cnt), 0);
    chk({tag, " empty"}, 32'(empty), 1);
    chk({tag, " full"}, 32'(full), 0);
    chk({tag, " count"}, 32'(count), 0);
  endtask
  initial begin
    logic [7:0] e;
    cyc = 0;
    rd_n = 0;
    checks = 0;
    errors = 0;
    rst_n = 1'b0;
    ovr_clr = 1'b0;
    bus.rx_d = 8'h00;
    bus.rxne = 1'b0;
    bus.txe = 1'b0;
    tick();
    tick();
    chk_reset("reset");
    rst_n = 1'b1;
    tick();
    n0 = tx_q.size();
    bus.txe = 1'b1;
    bus.rx_d = 8'h41;
    bus.rxne = 1'b1;
    tick();
    chk("single rx_rd", 32'(bus.rx_rd), 1);
    chk("single count1", 32'(count), 1);
    chk("single last_rx", 32'(last_rx), 32'h41);
    chk("single tx_wr early", 32'(bus.tx_wr), 0);
    bus.rxne = 1'b0;
    tick();
    chk("single rx_rd off", 32'(bus.rx_rd), 0);
    chk("single tx_wr", 32'(bus.tx_wr), 1);
    chk("single tx_d", 32'(bus.tx_d), 32'h41);
    chk("single count0", 32'(count), 0);
    bus.txe = 1'b0;
    tick();
    tick();
    chk("single tx_wr off", 32'(bus.tx_wr), 0);
    chk("single rd pulses", 32'(rd_n), 1);
    chk("single wr pulses", 32'(tx_q.size() - n0), 1);
    for (int i = 0; i < 16; i++) send(8'(i));
    chk("burst full", 32'(full), 1);
    chk("burst count", 32'(count), 16);
    chk("burst no overrun", 32'(overrun), 0);
    send(8'hAA);
    chk("burst overrun", 32'(overrun), 1);
    chk("burst drop_cnt", 32'(drop_cnt), 1);
    chk("burst count kept", 32'(count), 16);
    chk("burst last_rx", 32'(last_rx), 32'hAA);
    chk("burst rd pulses", 32'(rd_n), 18);
    bus.rx_d = 8'h55;
    bus.rxne = 1'b1;
    bus.txe = 1'b1;
    tick();
    chk("simul tx_wr", 32'(bus.tx_wr), 1);
    chk("simul tx_d", 32'(bus.tx_d), 32'h00);
    chk("simul rx_rd", 32'(bus.rx_rd), 1);
    chk("simul count", 32'(count), 16);
    chk("simul drop_cnt", 32'(drop_cnt), 1);
    bus.rxne = 1'b0;
    bus.txe = 1'b0;
    tick();
    for (int j = 1; j <= 16; j++) begin
      e = j < 16 ? 8'(j) : 8'h55;
      bus.txe = 1'b1;
      tick();
      chk($sformatf("drain wr %0d", j), 32'(bus.tx_wr), 1);
      chk($sformatf("drain d %0d", j), 32'(bus.tx_d), 32'(e));
      bus.txe = 1'b0;
      tick();
    end
    chk("drain empty", 32'(empty), 1);
    chk("drain count", 32'(count), 0);
    n0 = rd_n;
    bus.rx_d = 8'h77;
    bus.rxne = 1'b1;
    repeat (5) tick();
    bus.rxne = 1'b0;
    tick();
    tick();
    chk("hold rd pulses", 32'(rd_n - n0), 1);
    chk("hold count", 32'(count), 1);
    bus.txe = 1'b1;
    tick();
    chk("hold tx_d", 32'(bus.tx_d), 32'h77);
    bus.txe = 1'b0;
    tick();
    send(8'h31);
    send(8'h32);
    send(8'h33);
    n0 = tx_q.size();
    bus.txe = 1'b1;
    repeat (40) tick();
    chk("stuck issues", 32'(tx_q.size() - n0), 3);
    if (tx_q.size() - n0 == 3) begin
      chk("stuck b0", 32'(tx_q[n0]), 32'h31);
      chk("stuck b1", 32'(tx_q[n0 + 1]), 32'h32);
      chk("stuck b2", 32'(tx_q[n0 + 2]), 32'h33);
      chk("stuck gap1", 32'(tx_t[n0 + 1] - tx_t[n0]), 9);
      chk("stuck gap2", 32'(tx_t[n0 + 2] - tx_t[n0 + 1]), 9);
    end
    bus.txe = 1'b0;
    for (int i = 0; i < 4; i++) send(8'h61 + 8'(i));
    chk("pre-reset count4", 32'(count), 4);
    bus.txe = 1'b1;
    tick();
    chk("pre-reset tx_wr", 32'(bus.tx_wr), 1);
    chk("pre-reset count3", 32'(count), 3);
    rst_n = 1'b0;
    tick();
    chk_reset("midreset");
    rst_n = 1'b1;
    n0 = tx_q.size();
    repeat (12) tick();
    chk("post-reset no tx", 32'(tx_q.size() - n0), 0);
    bus.txe = 1'b0;
    for (int i = 0; i < 17; i++) send(8'(i));
    chk("ovr set", 32'(overrun), 1);
    chk("ovr cnt", 32'(drop_cnt), 1);
    ovr_clr = 1'b1;
    tick();
    ovr_clr = 1'b0;
    chk("clr overrun", 32'(overrun), 0);
    chk("clr drop_cnt", 32'(drop_cnt), 0);
    bus.rx_d = 8'hEE;
    bus.rxne = 1'b1;
    ovr_clr = 1'b1;
    tick();
    ovr_clr = 1'b0;
    bus.rxne = 1'b0;
    chk("clr+drop overrun", 32'(overrun), 1);
    chk("clr+drop drop_cnt", 32'(drop_cnt), 1);
    tick();
    send(8'hEF);
    chk("second drop cnt", 32'(drop_cnt), 2);
    chk("second drop last_rx", 32'(last_rx), 32'hEF);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
